instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- IF stage initiator for the single-cycle-read instruction memory.
- Owns the PC and drives the word-aligned fetch address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush, branch/jump redirect and a halt state so the pipeline stops cleanly at program end.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that ends fetch.
- NOP_WORD, 32'h0000_0000, bubble inserted into IF/ID on flush/redirect.

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- FetchAddress  out  32  byte address to instruction memory; equals PC, bits[1:0] always 0.
- FetchInstruction  in  32  instruction returned combinationally for FetchAddress in the same cycle.
- Stall  in  1  hold PC and IF/ID (load-use hazard from ID).
- Flush  in  1  replace IF/ID contents with bubble.
- BranchTaken  in  1  redirect to BranchTarget.
- BranchTarget  in  32  branch destination byte address.
- Jump  in  1  redirect to JumpTarget.
- JumpTarget  in  32  jump destination byte address.
- IF_ID_Instruction  out  32  registered instruction to decode.
- IF_ID_PCPlus4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  IF/ID holds a real instruction.
- Halted  out  1  fetch has stopped on HALT_WORD.

Behaviour:
- Interface: one clock, Clk; Reset synchronous, active-high.
- Reset values:
  - PC = RESET_PC.
  - IF_ID_Instruction = NOP_WORD, IF_ID_PCPlus4 = 0, IF_ID_Valid = 0.
  - Halted = 0; state = RUN.
  - Reset asserted mid-operation (any state, any redirect pending) takes effect at the next edge, no residue.
- FetchAddress = {PC[31:2],2'b00}, combinational from the PC register. Instruction latency: 1 cycle from PC to IF/ID.
- Next-PC priority (highest first):
  - Reset.
  - Jump: PC = {JumpTarget[31:2],00}.
  - BranchTaken: PC = {BranchTarget[31:2],00}.
  - HALTED: PC held.
  - Stall: PC held.
  - Otherwise: PC = PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- Jump and BranchTaken in the same cycle: Jump wins.
- IF/ID update, priority order:
  - Redirect or Flush: load NOP_WORD, Valid = 0.
  - Stall (no redirect/flush): hold all IF/ID fields.
  - Otherwise: load FetchInstruction and PC+4, Valid = 1.
- Redirect overrides Stall: PC takes the target and IF/ID is bubbled.
- State machine, states RUN and HALTED:
  - RUN → HALTED when IF/ID loads HALT_WORD (Valid = 1).
  - In HALTED: Halted = 1, PC frozen, IF/ID frozen holding HALT_WORD with Valid = 1.
  - HALTED → RUN only on Jump or BranchTaken, which also clears Halted. This allows a branch already in ID to squash the halt.
  - HALTED → RUN on Reset.
  - Flush in HALTED bubbles IF/ID but stays HALTED.

Optional Feature:
- Macro FETCH_TRACE_EN.
- Defined: each edge where IF/ID loads (not stalled), $display "IFU: PC=%h instr=%h redirect=%b", plus one line on entering HALTED. Simulation only.
- Undefined: no display statements compiled; identical RTL behaviour.

Decomposition:
- Shared package/header fetch_pkg holds:
  - RESET_PC, HALT_WORD, NOP_WORD defaults.
  - State encoding (RUN = 1'b0, HALTED = 1'b1).
  - Width constant for a 32-bit word.
- One sub-module: pc_next_sel, combinational next-PC priority mux with alignment masking. The top level holds the PC register, IF/ID register and FSM.

Test Plan:
- Reset then 4 free-run cycles with memory word i = i*3 → FetchAddress 0,4,8,12; IF_ID_Instruction 0,3,6,9; PCPlus4 4,8,12,16; Valid 1 from the 2nd edge.
- Stall high 2 cycles at PC=0x10 → FetchAddress stays 0x10, IF/ID holds the 0x0C instruction, then resumes at 0x14.
- BranchTaken=1, BranchTarget=0x43 with Stall=1 → next FetchAddress 0x40, IF_ID_Valid 0, IF_ID_Instruction NOP_WORD.
- Jump (0x100) and BranchTaken (0x200) same cycle → FetchAddress 0x100.
- HALT_WORD at address 0x20 → Halted=1 one edge after fetch, PC frozen at 0x24 for 10 cycles; then Jump to 0x0 → Halted=0, fetch from 0x0.
- PC forced via jump to 0xFFFFFFFC → next FetchAddress 0x00000000; Reset asserted mid-stall → all outputs at reset values next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [WORD_W-1:0] NOP_WORD_DEF  = 32'h0000_0000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~WORD_W'(3);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: jump > branch > hold > sequential, always word aligned.
module pc_next_sel
  import fetch_pkg::*;
(
  input  logic [WORD_W-1:0] i_pc,
  input  logic              i_jump,
  input  logic [WORD_W-1:0] i_jump_target,
  input  logic              i_branch,
  input  logic [WORD_W-1:0] i_branch_target,
  input  logic              i_hold,
  output logic [WORD_W-1:0] o_pc_next_c,
  output logic [WORD_W-1:0] o_pc_plus4_c
);

  // Select the next PC; sequential increment wraps modulo 2^32.
  always_comb begin
    o_pc_plus4_c = i_pc + WORD_W'(4);
    o_pc_next_c  = i_pc;
    if (i_jump) begin
      o_pc_next_c = word_align(i_jump_target);
    end else if (i_branch) begin
      o_pc_next_c = word_align(i_branch_target);
    end else if (!i_hold) begin
      o_pc_next_c = word_align(o_pc_plus4_c);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC register, IF/ID pipeline register and RUN/HALTED control.
// Optional simulation trace of IF/ID loads is enabled by defining FETCH_TRACE_EN.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEF,
  parameter logic [WORD_W-1:0] NOP_WORD  = NOP_WORD_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic [WORD_W-1:0] FetchAddress,
  input  logic [WORD_W-1:0] FetchInstruction,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              BranchTaken,
  input  logic [WORD_W-1:0] BranchTarget,
  input  logic              Jump,
  input  logic [WORD_W-1:0] JumpTarget,
  output logic [WORD_W-1:0] IF_ID_Instruction,
  output logic [WORD_W-1:0] IF_ID_PCPlus4,
  output logic              IF_ID_Valid,
  output logic              Halted
);

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_ifid_instr;
  logic [WORD_W-1:0] r_ifid_pcp4;
  logic              r_ifid_valid;
  fetch_state_e      r_state;
  fetch_state_e      w_state_next;

  logic [WORD_W-1:0] w_fetch_addr;
  logic [WORD_W-1:0] w_pc_next;
  logic [WORD_W-1:0] w_pc_plus4;
  logic              w_redirect;
  logic              w_halted;
  logic              w_bubble;
  logic              w_load;

  assign w_fetch_addr = word_align(r_pc);
  assign w_redirect   = Jump | BranchTaken;
  assign w_halted     = (r_state == ST_HALTED);
  assign w_bubble     = w_redirect | Flush;
  assign w_load       = !w_bubble && !Stall && !w_halted;

  pc_next_sel u_pc_next_sel (
    .i_pc            (w_fetch_addr),
    .i_jump          (Jump),
    .i_jump_target   (JumpTarget),
    .i_branch        (BranchTaken),
    .i_branch_target (BranchTarget),
    .i_hold          (w_halted | Stall),
    .o_pc_next_c     (w_pc_next),
    .o_pc_plus4_c    (w_pc_plus4)
  );

  // PC register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // IF/ID register: bubble on redirect/flush, hold on stall or halt, else capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ifid_instr <= NOP_WORD;
      r_ifid_pcp4  <= '0;
      r_ifid_valid <= 1'b0;
    end else if (w_bubble) begin
      r_ifid_instr <= NOP_WORD;
      r_ifid_pcp4  <= '0;
      r_ifid_valid <= 1'b0;
    end else if (w_load) begin
      r_ifid_instr <= FetchInstruction;
      r_ifid_pcp4  <= w_pc_plus4;
      r_ifid_valid <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: halt once HALT_WORD is captured; only a redirect resumes.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_load && (FetchInstruction == HALT_WORD)) begin
          w_state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (w_redirect) begin
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign FetchAddress      = w_fetch_addr;
  assign IF_ID_Instruction = r_ifid_instr;
  assign IF_ID_PCPlus4     = r_ifid_pcp4;
  assign IF_ID_Valid       = r_ifid_valid;
  assign Halted            = w_halted;

`ifdef FETCH_TRACE_EN
  // Simulation trace of every IF/ID update and of the transition into HALTED.
  always_ff @(posedge Clk) begin
    if (!Reset && (w_bubble || w_load)) begin
      $display("IFU: PC=%h instr=%h redirect=%b", w_fetch_addr, FetchInstruction, w_redirect);
    end
    if (!Reset && (r_state == ST_RUN) && (w_state_next == ST_HALTED)) begin
      $display("IFU: entering HALTED at PC=%h", w_fetch_addr);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: reference model plus pinned literals.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        stall;
  logic        flush;
  logic        br;
  logic [31:0] bt;
  logic        jmp;
  logic [31:0] jt;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pcp4;
  logic        ifid_valid;
  logic        halted;

  logic [31:0] mem [0:1023];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcp4;
  logic        m_valid;
  logic        m_halted;
  logic        chk_en;

  int n_cmp;
  int n_bad;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  instruction_fetch_unit dut (
    .Clk               (clk),
    .Reset             (rst),
    .FetchAddress      (fetch_addr),
    .FetchInstruction  (fetch_instr),
    .Stall             (stall),
    .Flush             (flush),
    .BranchTaken       (br),
    .BranchTarget      (bt),
    .Jump              (jmp),
    .JumpTarget        (jt),
    .IF_ID_Instruction (ifid_instr),
    .IF_ID_PCPlus4     (ifid_pcp4),
    .IF_ID_Valid       (ifid_valid),
    .Halted            (halted)
  );

  // Single-cycle combinational instruction memory
  assign fetch_instr = mem[fetch_addr[11:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic step();
    logic [31:0] n_pc, n_instr, n_pcp4, fetched;
    logic        n_valid, n_halted, loads;
    fetched = mem[m_pc[11:2]];
    if (rst) begin
      n_pc = 32'h0; n_instr = NOP; n_pcp4 = 32'h0; n_valid = 1'b0; n_halted = 1'b0;
    end else begin
      n_pc = m_pc; n_instr = m_instr; n_pcp4 = m_pcp4; n_valid = m_valid; n_halted = m_halted;
      loads = 1'b0;
      if (jmp)                     n_pc = jt & ~32'h3;
      else if (br)                 n_pc = bt & ~32'h3;
      else if (!(m_halted || stall)) n_pc = m_pc + 32'd4;
      if (jmp || br || flush) begin
        n_instr = NOP; n_pcp4 = 32'h0; n_valid = 1'b0;
      end else if (!(stall || m_halted)) begin
        n_instr = fetched; n_pcp4 = m_pc + 32'd4; n_valid = 1'b1; loads = 1'b1;
      end
      if (jmp || br)                  n_halted = 1'b0;
      else if (loads && fetched == HALT) n_halted = 1'b1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pcp4 = n_pcp4; m_valid = n_valid; m_halted = n_halted;
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("FetchAddress", fetch_addr, m_pc);
      cmp("IF_ID_Valid", {31'h0, ifid_valid}, {31'h0, m_valid});
      cmp("IF_ID_Instruction", ifid_instr, m_instr);
      cmp("Halted", {31'h0, halted}, {31'h0, m_halted});
      if (m_valid) cmp("IF_ID_PCPlus4", ifid_pcp4, m_pcp4);
    end
  end

  task automatic clr();
    stall = 1'b0; flush = 1'b0; br = 1'b0; jmp = 1'b0; bt = 32'h0; jt = 32'h0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 1'b0;
    m_pc = 32'h0; m_instr = NOP; m_pcp4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 3);
    clr();
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    cmp("lit_rst_addr", fetch_addr, 32'h0);
    cmp("lit_rst_valid", {31'h0, ifid_valid}, 32'h0);
    cmp("lit_rst_instr", ifid_instr, NOP);
    cmp("lit_rst_halted", {31'h0, halted}, 32'h0);

    // Free run
    rst = 1'b0;
    step();
    cmp("lit_run1_addr", fetch_addr, 32'h4);
    cmp("lit_run1_pcp4", ifid_pcp4, 32'h4);
    cmp("lit_run1_valid", {31'h0, ifid_valid}, 32'h1);
    step();
    cmp("lit_run2_instr", ifid_instr, 32'd3);
    step(); step();
    cmp("lit_run4_addr", fetch_addr, 32'h10);
    cmp("lit_run4_instr", ifid_instr, 32'd9);
    cmp("lit_run4_pcp4", ifid_pcp4, 32'h10);

    // Stall two cycles then resume
    stall = 1'b1;
    step(); step();
    cmp("lit_stall_addr", fetch_addr, 32'h10);
    cmp("lit_stall_instr", ifid_instr, 32'd9);
    stall = 1'b0;
    step();
    cmp("lit_resume_addr", fetch_addr, 32'h14);
    cmp("lit_resume_instr", ifid_instr, 32'd12);

    // Flush in RUN: bubble, PC keeps advancing
    flush = 1'b1;
    step();
    cmp("lit_flush_valid", {31'h0, ifid_valid}, 32'h0);
    cmp("lit_flush_addr", fetch_addr, 32'h18);
    clr();

    // Branch overrides stall, target aligned
    br = 1'b1; bt = 32'h43; stall = 1'b1;
    step();
    cmp("lit_br_addr", fetch_addr, 32'h40);
    cmp("lit_br_valid", {31'h0, ifid_valid}, 32'h0);
    cmp("lit_br_instr", ifid_instr, NOP);
    clr();

    // Jump beats branch
    jmp = 1'b1; jt = 32'h100; br = 1'b1; bt = 32'h200;
    step();
    cmp("lit_jmp_addr", fetch_addr, 32'h100);
    clr();

    // Halt at 0x20
    mem[8] = HALT;
    jmp = 1'b1; jt = 32'h18;
    step();
    clr();
    step(); step(); step();
    cmp("lit_halt_flag", {31'h0, halted}, 32'h1);
    cmp("lit_halt_instr", ifid_instr, HALT);
    cmp("lit_halt_addr", fetch_addr, 32'h24);
    repeat (10) step();
    cmp("lit_halt10_addr", fetch_addr, 32'h24);
    cmp("lit_halt10_valid", {31'h0, ifid_valid}, 32'h1);
    flush = 1'b1;
    step();
    cmp("lit_hflush_valid", {31'h0, ifid_valid}, 32'h0);
    cmp("lit_hflush_halted", {31'h0, halted}, 32'h1);
    clr();
    jmp = 1'b1; jt = 32'h0;
    step();
    cmp("lit_unhalt_flag", {31'h0, halted}, 32'h0);
    cmp("lit_unhalt_addr", fetch_addr, 32'h0);
    clr();
    step();
    cmp("lit_unhalt_next", fetch_addr, 32'h4);

    // PC wrap
    jmp = 1'b1; jt = 32'hFFFF_FFFC;
    step();
    cmp("lit_wrap_top", fetch_addr, 32'hFFFF_FFFC);
    clr();
    step();
    cmp("lit_wrap_addr", fetch_addr, 32'h0);
    cmp("lit_wrap_pcp4", ifid_pcp4, 32'h0);
    cmp("lit_wrap_instr", ifid_instr, 32'd3069);

    // Reset mid-stall with a redirect pending
    stall = 1'b1;
    step();
    rst = 1'b1; br = 1'b1; bt = 32'h80;
    step();
    cmp("lit_rst2_addr", fetch_addr, 32'h0);
    cmp("lit_rst2_valid", {31'h0, ifid_valid}, 32'h0);
    cmp("lit_rst2_pcp4", ifid_pcp4, 32'h0);
    cmp("lit_rst2_instr", ifid_instr, NOP);
    rst = 1'b0;
    clr();

    // Reset while halted
    jmp = 1'b1; jt = 32'h20;
    step();
    clr();
    step();
    cmp("lit_halt2_flag", {31'h0, halted}, 32'h1);
    rst = 1'b1; jmp = 1'b1; jt = 32'h300;
    step();
    cmp("lit_rst3_halted", {31'h0, halted}, 32'h0);
    cmp("lit_rst3_addr", fetch_addr, 32'h0);
    rst = 1'b0;
    clr();
    step();
    cmp("lit_rst3_next", fetch_addr, 32'h4);

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
